// File: rtl/irq_pending_ctrl_if.sv
// Interrupt request/offer bundle between the pending controller, its external
// priority encoder and the interrupt consumer.
interface irq_pending_ctrl_if;
  logic [7:0] irq_in;
  logic       mask_wr;
  logic [7:0] mask_data;
  logic [7:0] pend_vec;
  logic [2:0] enc_out;
  logic       enc_valid;
  logic [2:0] irq_id;
  logic       irq_valid;
  logic       irq_ready;
  logic       irq_drop;

  modport slave (
    input  irq_in, mask_wr, mask_data, enc_out, enc_valid, irq_ready,
    output pend_vec, irq_id, irq_valid, irq_drop
  );

  modport master (
    output irq_in, mask_wr, mask_data, enc_out, enc_valid, irq_ready,
    input  pend_vec, irq_id, irq_valid, irq_drop
  );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Edge-triggered interrupt pending register with synchronisers, drop detect and
// a two-state offer FSM. Define IRQ_PENDING_MASK_EN to build the mask register.

// One request line: synchroniser chain, history flop and rising-edge detect.
module irq_pending_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], irq};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~hist;
endmodule

module irq_pending_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  irq_pending_ctrl_if.slave  bus
);
  localparam int NUM_LANES = 8;

  typedef enum logic {IDLE, OFFER} state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] id;
  } offer_t;

  state_t                 state, state_nxt;
  offer_t                 offer_q, offer_nxt;
  logic [NUM_LANES-1:0]   rise;
  logic [NUM_LANES-1:0]   pending, pending_nxt;
  logic [NUM_LANES-1:0]   clr;
  logic [NUM_LANES-1:0]   mask;
  logic                   accept;
  logic                   drop_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    irq_pending_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .irq   (bus.irq_in[g]),
      .rise  (rise[g])
    );
  end

  assign accept = (state == OFFER) && bus.irq_ready;
  assign clr    = accept ? (8'd1 << offer_q.id) : '0;

  // A fresh edge overrides the accept-clear so a request arriving in the
  // accept cycle is kept.
  assign pending_nxt = (pending & ~clr) | rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      drop_q  <= 1'b0;
    end else begin
      pending <= pending_nxt;
      drop_q  <= |(rise & pending & ~clr);
    end
  end

`ifdef IRQ_PENDING_MASK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           mask <= '0;
    else if (bus.mask_wr) mask <= bus.mask_data;
  end
`else
  assign mask = '0;
  wire unused_mask_in = ^{bus.mask_wr, bus.mask_data};
`endif

  assign bus.pend_vec = pending & ~mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      offer_q <= '0;
    end else begin
      state   <= state_nxt;
      offer_q <= offer_nxt;
    end
  end

  // The offer is frozen in OFFER; encoder changes only matter back in IDLE.
  always_comb begin
    state_nxt = state;
    offer_nxt = offer_q;
    case (state)
      IDLE: begin
        if (bus.enc_valid) begin
          offer_nxt.id    = bus.enc_out;
          offer_nxt.valid = 1'b1;
          state_nxt       = OFFER;
        end
      end
      OFFER: begin
        if (bus.irq_ready) begin
          offer_nxt.valid = 1'b0;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.irq_id    = offer_q.id;
  assign bus.irq_valid = offer_q.valid;
  assign bus.irq_drop  = drop_q;
endmodule
